// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and lock FSM encodings for the Gray count receiver.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  // Callers zero-extend narrower counts; leading zeros do not disturb the prefix XOR.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic ham_is_one(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] d;
    d = a ^ b;
    return (d != '0) && ((d & (d - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_count_rx_sync_chain.sv
// Multi-flop synchronizer bringing a foreign-domain Gray count into clk.
module sync_chain #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_rx.sv
// Receives a Gray count from another clock domain, validates each +1 step,
// and exposes the decoded count, per-step ticks and a saturating total.
module gray_count_rx
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACC_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 tick,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 locked,
  output logic                 err_jump,
  output logic                 err_sticky
);

  localparam logic [ACC_WIDTH-1:0] TOTAL_MAX = '1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     s, p_q;
  logic [WIDTH-1:0]     s_bin, p_bin;
  logic                 same, step_ok;
  logic [WIDTH-1:0]     bin_d;
  logic                 tick_d, err_d, inc_d;
  logic [ACC_WIDTH-1:0] total_d;
  logic                 sticky_d;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (s)
  );

  // Step classification between the current and previous synchronized samples.
  always_comb begin
    s_bin   = WIDTH'(gray2bin(MAX_W'(s)));
    p_bin   = WIDTH'(gray2bin(MAX_W'(p_q)));
    same    = (s == p_q);
    step_ok = ham_is_one(MAX_W'(s), MAX_W'(p_q)) && (s_bin == p_bin + WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACQUIRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQUIRE: if (same) state_d = LOCKED;
      LOCKED:  if (!same && !step_ok) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
  end

  always_comb begin
    bin_d  = bin_out;
    tick_d = 1'b0;
    err_d  = 1'b0;
    inc_d  = 1'b0;
    case (state_q)
      ACQUIRE: if (same) bin_d = s_bin;
      LOCKED: begin
        if (!same) begin
          if (step_ok) begin
            bin_d  = s_bin;
            tick_d = 1'b1;
            inc_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // clear wins over the running total, but a same-cycle step or error still lands.
  always_comb begin
    total_d  = total;
    sticky_d = err_sticky | err_d;
    if (clear) begin
      total_d  = inc_d ? ACC_WIDTH'(1) : '0;
      sticky_d = err_d;
    end else if (inc_d && (total != TOTAL_MAX)) begin
      total_d = total + ACC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q        <= '0;
      bin_out    <= '0;
      tick       <= 1'b0;
      err_jump   <= 1'b0;
      err_sticky <= 1'b0;
      total      <= '0;
    end else begin
      p_q        <= s;
      bin_out    <= bin_d;
      tick       <= tick_d;
      err_jump   <= err_d;
      err_sticky <= sticky_d;
      total      <= total_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_gray_count_rx.sv
// Directed self-checking bench for gray_count_rx (main instance plus a narrow-total instance).
module tb_gray_count_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  gray_a, gray_b;
  logic        clear_a, clear_b;
  logic [3:0]  bin_a, bin_b;
  logic        tick_a, tick_b;
  logic [15:0] total_a;
  logic [3:0]  total_b;
  logic        locked_a, locked_b;
  logic        ej_a, ej_b;
  logic        es_a, es_b;

  int checks = 0;
  int errors = 0;
  int tick_cnt_a = 0;
  int tick_cnt_b = 0;
  int base;

  always #5 clk = ~clk;

  gray_count_rx #(.WIDTH(4), .SYNC_STAGES(2), .ACC_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .gray_in(gray_a), .clear(clear_a),
    .bin_out(bin_a), .tick(tick_a), .total(total_a), .locked(locked_a),
    .err_jump(ej_a), .err_sticky(es_a)
  );

  gray_count_rx #(.WIDTH(4), .SYNC_STAGES(2), .ACC_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .gray_in(gray_b), .clear(clear_b),
    .bin_out(bin_b), .tick(tick_b), .total(total_b), .locked(locked_b),
    .err_jump(ej_b), .err_sticky(es_b)
  );

  always @(negedge clk) begin
    if (tick_a === 1'b1) tick_cnt_a++;
    if (tick_b === 1'b1) tick_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input int unsigned b);
    logic [3:0] v;
    v = 4'(b % 16);
    return v ^ (v >> 1);
  endfunction

  initial begin
    rst = 1'b0; gray_a = 4'b0000; gray_b = 4'b0000; clear_a = 1'b0; clear_b = 1'b0;
    cycles(2);
    check("reset_bin", 32'(bin_a), 32'd0);
    check("reset_locked", 32'(locked_a), 32'd0);
    check("reset_total", 32'(total_a), 32'd0);
    rst = 1'b1;

    // Baseline acquisition at 0
    cycles(4);
    check("lock_locked", 32'(locked_a), 32'd1);
    check("lock_bin", 32'(bin_a), 32'd0);
    check("lock_total", 32'(total_a), 32'd0);
    check("lock_noticks", 32'(tick_cnt_a), 32'd0);

    // Four legal steps
    base = tick_cnt_a;
    gray_a = 4'b0001; cycles(3);
    gray_a = 4'b0011; cycles(3);
    gray_a = 4'b0010; cycles(3);
    gray_a = 4'b0110; cycles(3);
    cycles(2);
    check("seq_ticks", 32'(tick_cnt_a - base), 32'd4);
    check("seq_bin", 32'(bin_a), 32'd4);
    check("seq_total", 32'(total_a), 32'd4);
    check("seq_sticky", 32'(es_a), 32'd0);

    // Walk up to 15, then wrap to 0
    for (int k = 5; k <= 15; k++) begin
      gray_a = to_gray(k); cycles(3);
    end
    check("to15_bin", 32'(bin_a), 32'd15);
    check("to15_total", 32'(total_a), 32'd15);
    gray_a = 4'b0000; cycles(3);
    check("wrap_tick", 32'(tick_a), 32'd1);
    check("wrap_bin", 32'(bin_a), 32'd0);
    check("wrap_total", 32'(total_a), 32'd16);
    check("wrap_noerr", 32'(es_a), 32'd0);

    // Source reset while at 2
    gray_a = 4'b0001; cycles(3);
    gray_a = 4'b0011; cycles(3);
    check("pre_srst_total", 32'(total_a), 32'd18);
    gray_a = 4'b0000; cycles(3);
    check("srst_errjump", 32'(ej_a), 32'd1);
    check("srst_sticky", 32'(es_a), 32'd1);
    check("srst_unlocked", 32'(locked_a), 32'd0);
    check("srst_notick", 32'(tick_a), 32'd0);
    cycles(2);
    check("srst_relock", 32'(locked_a), 32'd1);
    check("srst_bin", 32'(bin_a), 32'd0);
    check("srst_total", 32'(total_a), 32'd18);
    check("srst_pulse_gone", 32'(ej_a), 32'd0);

    // Decrement 2 -> 1 is illegal
    gray_a = 4'b0001; cycles(3);
    gray_a = 4'b0011; cycles(3);
    gray_a = 4'b0001; cycles(3);
    check("dec_errjump", 32'(ej_a), 32'd1);
    cycles(2);
    check("dec_relock", 32'(locked_a), 32'd1);
    check("dec_bin", 32'(bin_a), 32'd1);
    check("dec_total", 32'(total_a), 32'd20);
    check("dec_sticky", 32'(es_a), 32'd1);

    // Clear coincident with the accepting cycle of step 1 -> 2
    gray_a = 4'b0011;
    cycles(2);
    clear_a = 1'b1;
    cycles(1);
    clear_a = 1'b0;
    check("clr_tick", 32'(tick_a), 32'd1);
    check("clr_total", 32'(total_a), 32'd1);
    check("clr_sticky", 32'(es_a), 32'd0);
    check("clr_bin", 32'(bin_a), 32'd2);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1;
    check("arst_bin", 32'(bin_a), 32'd0);
    check("arst_total", 32'(total_a), 32'd0);
    check("arst_locked", 32'(locked_a), 32'd0);
    check("arst_tick", 32'(tick_a), 32'd0);
    check("arst_errs", 32'({ej_a, es_a}), 32'd0);
    gray_a = 4'b0000;
    cycles(2);
    rst = 1'b1;
    cycles(4);
    check("b_lock", 32'(locked_b), 32'd1);

    // Narrow total saturates while ticks keep coming
    base = tick_cnt_b;
    for (int k = 1; k <= 20; k++) begin
      gray_b = to_gray(k); cycles(3);
      if (k == 15) check("b_total15", 32'(total_b), 32'd15);
    end
    cycles(1);
    check("b_sat_total", 32'(total_b), 32'd15);
    check("b_ticks", 32'(tick_cnt_b - base), 32'd20);
    check("b_bin", 32'(bin_b), 32'd4);
    check("b_noerr", 32'(es_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_count_rx.md
Name: gray_count_rx

Overview:
- Receive end of a cross-domain counter link: takes a WIDTH-bit Gray-coded count driven from a foreign clock domain and synchronizes it into `clk`.
- Decodes it to binary and validates every step as a legal single increment.
- Produces per-increment ticks plus a saturating running total for local logic.
- Sits at the `clk`-domain boundary beside any counter that exports its value in Gray code.

Parameters:
WIDTH, 4, bit width of the incoming Gray count.
SYNC_STAGES, 2, synchronizer flop depth (legal values 2..4).
ACC_WIDTH, 16, width of the running increment total.

Ports:
clk  input  1  receive-domain clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset.
gray_in  input  WIDTH  Gray count from foreign domain, asynchronous to clk.
clear  input  1  synchronous; zeroes total and err_sticky.
bin_out  output  WIDTH  last accepted count, binary.
tick  output  1  one-cycle pulse per accepted +1 step.
total  output  ACC_WIDTH  accepted increments since reset/clear, saturating.
locked  output  1  high while in LOCKED state.
err_jump  output  1  one-cycle pulse on an illegal step.
err_sticky  output  1  set by err_jump, cleared only by clear or reset.

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops, prev sample, bin_out, total = 0; tick, err_jump, err_sticky, locked = 0; state = ACQUIRE.
- Synchronizer: gray_in passes through SYNC_STAGES flops; output s. Register p holds the previous s.
- State ACQUIRE:
  - tick=0, locked=0, bin_out holds.
  - If s == p for one compare, go to LOCKED next cycle and load bin_out = gray2bin(s).
  - The baseline load does not count: no tick, total unchanged.
- State LOCKED (locked=1), each cycle compare s against p:
  - s == p: no action.
  - Hamming(s,p) == 1 and gray2bin(s) == gray2bin(p)+1 mod 2^WIDTH: accept.
    - bin_out = gray2bin(s).
    - tick=1 for that cycle.
    - total += 1, saturating at 2^ACC_WIDTH-1; tick still pulses when saturated.
  - Any other change is illegal:
    - Covers Hamming > 1, or a −1 step (Hamming 1 but decrement).
    - err_jump=1 for one cycle, err_sticky=1.
    - State goes to ACQUIRE; bin_out and total hold.
- Wrap: 2^WIDTH−1 → 0 is a legal +1 step (Gray 1000→0000 for WIDTH=4).
- Latency: a gray_in change is reflected on bin_out/tick SYNC_STAGES+1 cycles later.
- Source-side reset mid-run (count jumps to 0 from a value ≠ 2^WIDTH−1): err_jump, then relock onto 0 once stable.
- Source slower than clk is required. If the source steps twice between samples, the multi-bit change is flagged as err_jump; no silent miscounting.
- clear has priority over accumulation:
  - A clear in the same cycle as an accepted step gives total = 1 (cleared, then that step counted).
  - The same cycle's err_jump still sets err_sticky.
- Outputs are all registered; no combinational path from gray_in.
- State encoding: ACQUIRE=0, LOCKED=1.

Decomposition:
- Shared package/include gray_pkg holds:
  - gray2bin and bin2gray functions (parameterized by WIDTH);
  - state encodings ACQUIRE/LOCKED;
  - a Hamming-distance-is-one helper function.
- One sub-module, sync_chain (parameters WIDTH, SYNC_STAGES): multi-flop synchronizer with async active-low reset to 0.
- Lock FSM, step check and accumulator stay in gray_count_rx.

Test Plan:
- Reset then gray_in held at 0000 → locked=1 by cycle SYNC_STAGES+2; bin_out=0, total=0, no tick.
- Drive Gray 0000→0001→0011→0010→0110, each held 3 cycles → four ticks, bin_out ends 4, total=4, err_sticky=0.
- Step 1000 (15) → 0000 → tick, bin_out=0, total increments; no error.
- While locked at 0011 (2), force 0000 (source reset) → err_jump pulse, err_sticky=1, locked drops, then relocks with bin_out=0 and total unchanged.
- Decrement 0011→0001 → err_jump, relock at bin_out=1. Then assert clear coincident with the next legal step → total=1, err_sticky=0.
- ACC_WIDTH=4 with 20 legal steps → total saturates at 15 and ticks continue. Separately, assert rst low mid-stream → all outputs 0 immediately, without waiting for a clk edge.
